// File: rtl/activation_scheduler_if.sv
// Handshake, configuration and status bundle between the accumulator stream,
// the activation scheduler and the output buffer.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface activation_scheduler_if #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
);
  logic                         start;
  logic [CNT_WIDTH-1:0]         cfg_num_elems;
  logic                         cfg_relu_en;
  logic                         abort;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_last;
  logic                         busy;
  logic                         done;
  logic [CNT_WIDTH-1:0]         clamp_cnt;

  modport master (
    output start, cfg_num_elems, cfg_relu_en, abort, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, done, clamp_cnt
  );

  modport slave (
    input  start, cfg_num_elems, cfg_relu_en, abort, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, done, clamp_cnt
  );
endinterface

// File: rtl/activation_scheduler.sv
// Streams one configured burst of accumulator values through an optional ReLU
// into a single output register, with last flag, done pulse and clamp count.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module activation_scheduler #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  activation_scheduler_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  num_elems_q, num_elems_d;
  logic [CNT_WIDTH-1:0]  elem_cnt_q, elem_cnt_d;
  logic [CNT_WIDTH-1:0]  clamp_cnt_q, clamp_cnt_d;
  logic                  relu_en_q, relu_en_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic in_ready;
  logic accept;
  logic clamp;
  logic last_elem;

  // abort blocks acceptance in its own cycle so no element slips into a cancelled burst
  assign in_ready  = (state_q == S_RUN) && !bus.abort && (!out_valid_q || bus.out_ready);
  assign accept    = in_ready && bus.in_valid;
  assign clamp     = relu_en_q && bus.in_data[DATA_WIDTH-1];
  assign last_elem = (elem_cnt_q == num_elems_q - ONE);

  always_comb begin
    state_d     = state_q;
    num_elems_d = num_elems_q;
    relu_en_d   = relu_en_q;
    elem_cnt_d  = elem_cnt_q;
    clamp_cnt_d = clamp_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          num_elems_d = bus.cfg_num_elems;
          relu_en_d   = bus.cfg_relu_en;
          elem_cnt_d  = '0;
          clamp_cnt_d = '0;
          state_d     = (bus.cfg_num_elems == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else if (accept) begin
          out_data_d  = clamp ? '0 : bus.in_data;
          out_valid_d = 1'b1;
          out_last_d  = last_elem;
          elem_cnt_d  = elem_cnt_q + ONE;
          if (clamp) begin
            clamp_cnt_d = clamp_cnt_q + ONE;
          end
          if (last_elem) begin
            state_d = S_DRAIN;
          end
        end else if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (bus.abort) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      num_elems_q <= '0;
      relu_en_q   <= 1'b0;
      elem_cnt_q  <= '0;
      clamp_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      num_elems_q <= num_elems_d;
      relu_en_q   <= relu_en_d;
      elem_cnt_q  <= elem_cnt_d;
      clamp_cnt_q <= clamp_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.clamp_cnt = clamp_cnt_q;
endmodule

// File: doc/activation_scheduler.md
Name: activation_scheduler

Overview:
- Sequences a burst of pre-activation accumulator values through the ReLU datapath and returns the activated stream downstream.
- Sits between the accumulator/systolic-array output stream and the output buffer. It is configured per burst with an element count and a ReLU enable.
- Provides one-register valid/ready buffering, a last-beat flag, a done pulse and a count of clamped elements for sparsity statistics.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (global width header): signed element width.
- CNT_WIDTH, 16: width of the burst length and the statistics counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle burst start; sampled only in IDLE.
- cfg_num_elems  input  CNT_WIDTH  burst length; latched on accepted start.
- cfg_relu_en  input  1  1 = apply max(0,x), 0 = bypass; latched on accepted start.
- abort  input  1  synchronous cancel of the current burst.
- in_valid  input  1  upstream element valid.
- in_ready  output  1  scheduler accepts an element this cycle.
- in_data  input  DATA_WIDTH  signed pre-activation value.
- out_valid  output  1  output register holds a valid element.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_WIDTH  signed activated value.
- out_last  output  1  marks the final element of the burst; qualified by out_valid.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  one-cycle pulse at burst completion.
- clamp_cnt  output  CNT_WIDTH  number of elements zeroed by ReLU in the current or last burst.

Behaviour:
- Reset (async, rst=1): state=IDLE.
  - in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, clamp_cnt=0.
  - Internal elem_cnt=0 and latched configuration=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - On start=1, latch cfg_num_elems and cfg_relu_en, clear elem_cnt and clamp_cnt.
  - If cfg_num_elems==0, go to DONE. Otherwise go to RUN.
- RUN:
  - in_ready = !out_valid || out_ready (single-entry pipeline register; full throughput at 1 element/cycle).
  - On accept (in_valid && in_ready), the following take effect next cycle:
    - out_data = (relu_en && in_data<0) ? 0 : in_data;
    - out_valid=1;
    - out_last = (elem_cnt == num_elems-1);
    - elem_cnt++;
    - clamp_cnt++ if relu_en and in_data<0. The value 0 is not counted as clamped.
  - When the accepted element is the last one, go to DRAIN.
  - If out_valid && out_ready with no new accept, clear out_valid. out_data holds its last value.
- DRAIN:
  - in_ready=0.
  - On out_valid && out_ready, clear out_valid and out_last, and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. clamp_cnt holds until the next accepted start.
- Latency: element accepted in cycle N appears on out_data in cycle N+1.
- Back-pressure: while out_valid=1 and out_ready=0, out_data and out_last are held stable and in_ready=0.
- start outside IDLE is ignored, including start in the same cycle as done.
- abort in RUN or DRAIN:
  - Next cycle: state=IDLE, out_valid=0, out_last=0, no done pulse, clamp_cnt retains its partial value.
  - Any element offered in the abort cycle is not accepted (in_ready forced 0).
  - abort in IDLE or DONE has no effect.
- Bypass (relu_en=0): out_data = in_data bit-exact; clamp_cnt stays 0.
- Arithmetic:
  - Sign test on the MSB of in_data; no width change.
  - elem_cnt and clamp_cnt are CNT_WIDTH wide and cannot wrap within a burst, since the burst length is at most 2^CNT_WIDTH-1.
  - num_elems = 2^CNT_WIDTH-1 must complete correctly.
- Async reset mid-burst returns every output to its reset value immediately, without waiting for a clock edge.

Test Plan:
- DATA_WIDTH=8, start with num_elems=4, relu_en=1, inputs {5,-3,0,-128}, out_ready=1:
  - out_data {5,0,0,0} on 4 consecutive cycles, each 1 cycle after its accept;
  - out_last only on the 4th element;
  - done pulses 1 cycle after the last handshake;
  - clamp_cnt=2.
- Same inputs with relu_en=0: out_data {5,-3,0,-128} bit-exact, clamp_cnt=0.
- num_elems=3, out_ready held 0 for 3 cycles after the first output: out_data=7 held stable, in_ready=0, no element lost or duplicated; output order preserved.
- num_elems=0 with start: busy never asserts, done pulses 1 cycle after start, in_ready stays 0.
- abort after 2 of 5 elements: no done pulse; out_valid=0 next cycle; returns to IDLE; a new start with num_elems=1 and input -1 gives out_data=0, out_last=1, clamp_cnt=1.
- rst asserted asynchronously mid-RUN: all outputs are 0 before the next clock edge; a subsequent start runs a clean burst.
